// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_write_arbiter
//  Purpose : Two-requester burst write arbiter in front of a shared FIFO.
//            Round-robin by default; define FIFO_ARB_STRICT_PRIORITY_EN for
//            fixed priority to requester 0.
//  Rev     : 1.0  initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    input  logic [DATA_SIZE-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_SIZE-1:0] req1_data,
    output logic                 req1_ready,
    input  logic                 fifo_full,
    output logic                 write_to_fifo,
    output logic [DATA_SIZE-1:0] write_data_out,
    output logic [1:0]           grant
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;
    localparam logic [3:0] C_LAST   = 4'(BURST_LEN - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       sel_valid;
    logic       xfer;
    logic       pick1;

    // Owner's valid qualified by FIFO space; IDLE never transfers.
    always_comb begin
        sel_valid = 1'b0;
        case (state_q)
            S_GRANT0: sel_valid = req0_valid;
            S_GRANT1: sel_valid = req1_valid;
            default:  sel_valid = 1'b0;
        endcase
        xfer = sel_valid & ~fifo_full;
    end

`ifdef FIFO_ARB_STRICT_PRIORITY_EN
    always_comb begin
        pick1 = ~req0_valid;
    end
`else
    logic last_owner_q, last_owner_d;

    // last_owner resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == S_GRANT0 && (!req0_valid || (xfer && burst_cnt_q == C_LAST))) begin
            last_owner_d = 1'b0;
        end else if (state_q == S_GRANT1 && (!req1_valid || (xfer && burst_cnt_q == C_LAST))) begin
            last_owner_d = 1'b1;
        end
        pick1 = req1_valid & (~req0_valid | ~last_owner_q);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                burst_cnt_d = 4'd0;
                if (req0_valid || req1_valid) begin
                    state_d = pick1 ? S_GRANT1 : S_GRANT0;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (!sel_valid) begin
                    state_d     = S_IDLE;
                    burst_cnt_d = 4'd0;
                end else if (xfer) begin
                    if (burst_cnt_q == C_LAST) begin
                        state_d     = S_IDLE;
                        burst_cnt_d = 4'd0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                burst_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        grant          = 2'b00;
        write_data_out = '0;
        write_to_fifo  = xfer;
        case (state_q)
            S_GRANT0: begin
                req0_ready     = ~fifo_full;
                grant          = 2'b01;
                write_data_out = req0_data;
            end
            S_GRANT1: begin
                req1_ready     = ~fifo_full;
                grant          = 2'b10;
                write_data_out = req1_data;
            end
            default: begin
                req0_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 8, SHALL set the word width of both requester data inputs and the FIFO write data output.
REQ-002 Parameter BURST_LEN, default 4, legal range 1..15, SHALL set the maximum number of words accepted per grant.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 has a word on req0_data.
REQ-006 req0_data  input  DATA_SIZE  requester 0 data word.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle when req0_valid also high.
REQ-008 req1_valid  input  1  requester 1 has a word on req1_data.
REQ-009 req1_data  input  DATA_SIZE  requester 1 data word.
REQ-010 req1_ready  output  1  requester 1 word accepted this cycle when req1_valid also high.
REQ-011 fifo_full  input  1  full flag from the shared FIFO.
REQ-012 write_to_fifo  output  1  FIFO write strobe, one word per high cycle.
REQ-013 write_data_out  output  DATA_SIZE  word written to the FIFO.
REQ-014 grant  output  2  one-hot current owner (bit0 = requester 0, bit1 = requester 1), 2'b00 when idle.

Function
REQ-015 The block SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-016 IDLE: both readys low, write_to_fifo low, grant 2'b00; if any valid is high, next state SHALL be GRANT0 or GRANT1 per REQ-017, burst counter cleared to 0.
REQ-017 Round robin: both valids high -> grant the requester not equal to last_owner; exactly one valid high -> grant that requester.
REQ-018 GRANTx: readyx = ~fifo_full; other ready low; grant = one-hot x.
REQ-019 Transfer in GRANTx occurs when validx & ~fifo_full: write_to_fifo high same cycle (combinational), write_data_out = datax, burst counter increments.
REQ-020 write_data_out SHALL be the granted requester's data in GRANTx and all-zero in IDLE.
REQ-021 GRANTx -> IDLE when a transfer occurs with burst counter == BURST_LEN-1, or when validx is low (no transfer that cycle); last_owner <= x on exit.
REQ-022 fifo_full high in GRANTx: no transfer, counter holds, state holds (grant not released while requester still valid).
REQ-023 Re-arbitration SHALL cost exactly one IDLE cycle between grants; maximum sustained throughput BURST_LEN words per BURST_LEN+1 cycles.
REQ-024 Non-granted requester's valid/data SHALL have no effect on outputs.
REQ-025 Burst counter SHALL be 4 bits and never exceed BURST_LEN-1.
REQ-026 fifo_full and a final burst transfer never coincide (full suppresses transfer); exit occurs only on the cycle the last word is written.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, burst counter 0, last_owner = requester 1 (so requester 0 wins first tie).
REQ-028 During and after reset, until the first grant: req0_ready = req1_ready = 0, write_to_fifo = 0, write_data_out = 0, grant = 2'b00.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no write strobe after assertion; words already written stay written.

Configuration
REQ-030 Macro FIFO_ARB_STRICT_PRIORITY_EN defined: IDLE SHALL always grant requester 0 when req0_valid is high, requester 1 only when req0_valid low; last_owner ignored; burst limit still applies.
REQ-031 Macro undefined: round-robin per REQ-017.

Verification
REQ-032 Reset release, req0_valid=1 with data 0x11,0x12,0x13,0x14,0x15, req1 idle, BURST_LEN=4 -> FIFO receives 0x11..0x14, one IDLE cycle, then 0x15; grant 01 throughout grants.
REQ-033 Both valid from same cycle after reset, continuous data A0.., B0.. -> FIFO order A0-A3, B0-B3, A4-A7 (round robin); with FIFO_ARB_STRICT_PRIORITY_EN -> A0-A7 with no B words while req0_valid high.
REQ-034 GRANT0 after 2 words, fifo_full=1 for 3 cycles -> req0_ready=0, write_to_fifo=0, grant stays 01; on full release remaining 2 words written, then IDLE.
REQ-035 GRANT1, req1_valid drops after 1 word with req0_valid high -> next cycle IDLE, following cycle grant 01.
REQ-036 reset_n pulsed low mid-burst of requester 1 -> write_to_fifo and req1_ready low in the same cycle; after release with both valid, requester 0 granted first.
